// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared codec audio link types and constants
// Contents:
//   AUDIO_DATA_WIDTH : default bits per channel word
//   AUDIO_LEFT_POL   : LRCK level that marks the left channel
//   rx_state_e       : receive deserialiser states
//   audio_pair_t     : stereo sample pair {left, right}
package audio_pkg;

    localparam int   AUDIO_DATA_WIDTH = 16;
    localparam logic AUDIO_LEFT_POL   = 1'b1;

    typedef enum logic [1:0] {
        RX_SYNC  = 2'd0,
        RX_SHIFT = 2'd1,
        RX_HOLD  = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic [AUDIO_DATA_WIDTH-1:0] left;
        logic [AUDIO_DATA_WIDTH-1:0] right;
    } audio_pair_t;

endpackage

// File: rtl/audio_pin_sync.sv
// rtl/audio_pin_sync.sv - N-stage pin synchroniser with rise/fall strobes
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   pin_i      : asynchronous input pin
//   sync_o     : synchronised level (STAGES flops deep)
//   rise_o     : one-cycle strobe on a synchronised 0->1 transition
//   fall_o     : one-cycle strobe on a synchronised 1->0 transition
module audio_pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int             FW        = $clog2(STAGES + 2);
    localparam logic [FW-1:0]  FILL_DONE = FW'(STAGES + 1);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              hist_q, hist_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic              armed;

    // Strobes stay quiet until the chain and history flop hold real pin
    // samples, so a pin resting high through reset is not seen as an edge.
    assign armed = (fill_q == FILL_DONE);

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], pin_i};
        hist_d = sync_q[STAGES-1];
        fill_d = armed ? fill_q : fill_q + FW'(1);
    end

    assign sync_o = sync_q[STAGES-1];
    assign rise_o = armed &  sync_q[STAGES-1] & ~hist_q;
    assign fall_o = armed & ~sync_q[STAGES-1] &  hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            fill_q <= '0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/audio_adc_rx.sv
// rtl/audio_adc_rx.sv - codec ADC serial receiver with valid/ready sample pair output
// Ports:
//   iCLK_18_4, iRST_N              : system clock, asynchronous active-low reset
//   iAUD_BCK, iAUD_LRCK, iAUD_ADCDAT : oversampled codec serial link (left-justified, MSB first)
//   oLEFT, oRIGHT, oVALID, iREADY  : published stereo pair and handshake
//   oOVERRUN                       : pulse when a completed pair is dropped under backpressure
//   oSHORT                         : pulse when LRCK toggles before a full word arrived
// Optional (AUDIO_ADC_RX_PEAK_EN): iPEAK_CLR, oPEAK_L, oPEAK_R peak magnitude trackers.
module audio_adc_rx
    import audio_pkg::*;
#(
    parameter int   DATA_WIDTH  = AUDIO_DATA_WIDTH,
    parameter logic LEFT_POL    = AUDIO_LEFT_POL,
    parameter int   SYNC_STAGES = 2
) (
    input  logic                  iCLK_18_4,
    input  logic                  iRST_N,
    input  logic                  iAUD_BCK,
    input  logic                  iAUD_LRCK,
    input  logic                  iAUD_ADCDAT,
`ifdef AUDIO_ADC_RX_PEAK_EN
    input  logic                  iPEAK_CLR,
    output logic [DATA_WIDTH-2:0] oPEAK_L,
    output logic [DATA_WIDTH-2:0] oPEAK_R,
`endif
    output logic [DATA_WIDTH-1:0] oLEFT,
    output logic [DATA_WIDTH-1:0] oRIGHT,
    output logic                  oVALID,
    input  logic                  iREADY,
    output logic                  oOVERRUN,
    output logic                  oSHORT
);

    localparam int            CW       = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);

    logic bck_rise, bck_fall, bck_sync;
    logic lrck_rise, lrck_fall, lrck_sync, lrck_edge;
    logic dat_sync, dat_rise, dat_fall;
    logic unused_sinks;

    audio_pin_sync #(.STAGES(SYNC_STAGES)) u_bck_sync (
        .clk(iCLK_18_4), .rst_n(iRST_N), .pin_i(iAUD_BCK),
        .sync_o(bck_sync), .rise_o(bck_rise), .fall_o(bck_fall)
    );

    audio_pin_sync #(.STAGES(SYNC_STAGES)) u_lrck_sync (
        .clk(iCLK_18_4), .rst_n(iRST_N), .pin_i(iAUD_LRCK),
        .sync_o(lrck_sync), .rise_o(lrck_rise), .fall_o(lrck_fall)
    );

    // Same depth as BCK so the data bit lines up with bck_rise.
    audio_pin_sync #(.STAGES(SYNC_STAGES)) u_dat_sync (
        .clk(iCLK_18_4), .rst_n(iRST_N), .pin_i(iAUD_ADCDAT),
        .sync_o(dat_sync), .rise_o(dat_rise), .fall_o(dat_fall)
    );

    assign lrck_edge    = lrck_rise | lrck_fall;
    assign unused_sinks = ^{bck_sync, bck_fall, dat_rise, dat_fall};

    rx_state_e             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  chan_q, chan_d;          // 1 = left channel
    logic [DATA_WIDTH-1:0] left_stg_q, left_stg_d;
    logic                  have_left_q, have_left_d;
    logic                  pub_q, pub_d;
    logic [DATA_WIDTH-1:0] pub_left_q, pub_left_d;
    logic [DATA_WIDTH-1:0] pub_right_q, pub_right_d;
    logic                  short_q, short_d;
    logic [DATA_WIDTH-1:0] left_q, left_d;
    logic [DATA_WIDTH-1:0] right_q, right_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;
    logic                  load;

    logic                  store;
    logic [DATA_WIDTH-1:0] store_word;
    logic                  restart;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        chan_d      = chan_q;
        left_stg_d  = left_stg_q;
        have_left_d = have_left_q;
        pub_d       = 1'b0;
        pub_left_d  = pub_left_q;
        pub_right_d = pub_right_q;
        short_d     = 1'b0;
        store       = 1'b0;
        store_word  = '0;
        restart     = 1'b0;

        case (state_q)
            RX_SYNC: begin
                if (lrck_edge) begin
                    state_d = RX_SHIFT;
                    chan_d  = (lrck_sync == LEFT_POL);
                    restart = 1'b1;
                end
            end
            RX_SHIFT: begin
                if (lrck_edge) begin
                    // Partial words are left-aligned; a full word shifts by 0.
                    store      = 1'b1;
                    store_word = shreg_q << (CNT_FULL - cnt_q);
                    short_d    = (cnt_q != CNT_FULL);
                    chan_d     = ~chan_q;
                    restart    = 1'b1;
                end else if (cnt_q == CNT_FULL) begin
                    store      = 1'b1;
                    store_word = shreg_q;
                    state_d    = RX_HOLD;
                end else if (bck_rise) begin
                    shreg_d = {shreg_q[DATA_WIDTH-2:0], dat_sync};
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            RX_HOLD: begin
                if (lrck_edge) begin
                    state_d = RX_SHIFT;
                    chan_d  = ~chan_q;
                    restart = 1'b1;
                end
            end
            default: state_d = RX_SYNC;
        endcase

        // A bit clocked in alongside the LRCK edge is the new word's MSB.
        if (restart) begin
            state_d = RX_SHIFT;
            cnt_d   = '0;
            shreg_d = '0;
            if (bck_rise) begin
                shreg_d = {{(DATA_WIDTH-1){1'b0}}, dat_sync};
                cnt_d   = CW'(1);
            end
        end

        if (store) begin
            if (chan_q) begin
                left_stg_d  = store_word;
                have_left_d = 1'b1;
            end else begin
                // A right word without its left partner is dropped silently.
                if (have_left_q) begin
                    pub_d       = 1'b1;
                    pub_left_d  = left_stg_q;
                    pub_right_d = store_word;
                end
                have_left_d = 1'b0;
            end
        end
    end

    always_comb begin
        left_d    = left_q;
        right_d   = right_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        load      = 1'b0;
        if (pub_q) begin
            if (!valid_q || iREADY) begin
                load    = 1'b1;
                left_d  = pub_left_q;
                right_d = pub_right_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && iREADY) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= RX_SYNC;
            cnt_q       <= '0;
            shreg_q     <= '0;
            chan_q      <= 1'b0;
            left_stg_q  <= '0;
            have_left_q <= 1'b0;
            pub_q       <= 1'b0;
            pub_left_q  <= '0;
            pub_right_q <= '0;
            short_q     <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            chan_q      <= chan_d;
            left_stg_q  <= left_stg_d;
            have_left_q <= have_left_d;
            pub_q       <= pub_d;
            pub_left_q  <= pub_left_d;
            pub_right_q <= pub_right_d;
            short_q     <= short_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign oLEFT    = left_q;
    assign oRIGHT   = right_q;
    assign oVALID   = valid_q;
    assign oOVERRUN = overrun_q;
    assign oSHORT   = short_q;

`ifdef AUDIO_ADC_RX_PEAK_EN
    // Magnitude of a two's complement sample; the most negative value
    // saturates to the largest positive magnitude.
    function automatic logic [DATA_WIDTH-2:0] mag(input logic [DATA_WIDTH-1:0] x);
        logic [DATA_WIDTH-1:0] n;
        n = ~x + 1'b1;
        if (!x[DATA_WIDTH-1]) return x[DATA_WIDTH-2:0];
        if (n[DATA_WIDTH-1])  return '1;
        return n[DATA_WIDTH-2:0];
    endfunction

    logic [DATA_WIDTH-2:0] peak_l_q, peak_l_d, peak_r_q, peak_r_d;

    always_comb begin
        peak_l_d = peak_l_q;
        peak_r_d = peak_r_q;
        if (iPEAK_CLR) begin
            peak_l_d = '0;
            peak_r_d = '0;
        end else if (load) begin
            if (mag(pub_left_q)  > peak_l_q) peak_l_d = mag(pub_left_q);
            if (mag(pub_right_q) > peak_r_q) peak_r_d = mag(pub_right_q);
        end
    end

    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            peak_l_q <= '0;
            peak_r_q <= '0;
        end else begin
            peak_l_q <= peak_l_d;
            peak_r_q <= peak_r_d;
        end
    end

    assign oPEAK_L = peak_l_q;
    assign oPEAK_R = peak_r_q;
`endif

endmodule
